// File: rtl/adder8.sv
// rtl/adder8.sv - registered WIDTH-bit add/subtract with carry, overflow and zero flags, 1-cycle latency
module adder8 #(
    parameter int WIDTH  = 8,
    parameter bit SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH:0]   sum,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    logic             do_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_next;
    logic             ovf_next;
    logic             zero_next;

    // Subtraction is a + ~b + cin, so cin=1 gives a-b and sum[WIDTH] reads as NOT-borrow.
    always_comb begin
        do_sub    = SUB_EN && sub;
        b_eff     = do_sub ? ~b : b;
        sum_next  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        ovf_next  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
        zero_next = (sum_next[WIDTH-1:0] == '0);
    end

    // Result registers load only on an accepted input, so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                ovf  <= ovf_next;
                zero <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_adder8.sv
// tb/tb_adder8.sv - vector-table and sequence bench for adder8
module tb_adder8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic [8:0] sum;
    logic       out_valid;
    logic       ovf;
    logic       zero;

    int n_cmp = 0;
    int n_fail = 0;

    adder8 #(.WIDTH(8), .SUB_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .sub(sub),
        .sum(sum), .out_valid(out_valid), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] sum;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic-level reference: subtract is a - b + 255 + cin, overflow from signed range.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mcin,
                         input logic msub, output logic [8:0] esum, output logic eovf,
                         output logic ezero);
        int u;
        int s;
        int sa;
        int sb;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            u = int'(ma) - int'(mb) + 255 + int'(mcin);
            s = sa - sb - 1 + int'(mcin);
        end else begin
            u = int'(ma) + int'(mb) + int'(mcin);
            s = sa + sb + int'(mcin);
        end
        esum  = u[8:0];
        eovf  = (s > 127) || (s < -128);
        ezero = (u[7:0] == 8'd0);
    endtask

    initial begin
        logic [8:0] esum;
        logic       eovf;
        logic       ezero;
        logic [8:0] hold_sum;
        logic       hold_ovf;
        logic       hold_zero;

        vecs[0] = '{8'd25,  8'd17,  1'b0, 1'b0, 9'd42,   1'b0, 1'b0};
        vecs[1] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 9'h1FF,  1'b0, 1'b0};
        vecs[2] = '{8'h80,  8'h80,  1'b0, 1'b0, 9'h100,  1'b1, 1'b1};
        vecs[3] = '{8'h7F,  8'h01,  1'b0, 1'b0, 9'h080,  1'b1, 1'b0};
        vecs[4] = '{8'd10,  8'd3,   1'b1, 1'b1, 9'h107,  1'b0, 1'b0};
        vecs[5] = '{8'd3,   8'd10,  1'b1, 1'b1, 9'h0F9,  1'b0, 1'b0};
        vecs[6] = '{8'd5,   8'd5,   1'b1, 1'b1, 9'h100,  1'b0, 1'b1};
        vecs[7] = '{8'd5,   8'd5,   1'b0, 1'b1, 9'h0FF,  1'b0, 1'b0};
        vecs[8] = '{8'h80,  8'h01,  1'b1, 1'b1, 9'h17F,  1'b1, 1'b0};

        #2;
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 9; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
        end

        // Idle cycle with junk inputs: valid drops, result and flags hold.
        in_valid = 1'b0; a = 8'h5A; b = 8'hC3; cin = 1'b1; sub = 1'b0;
        @(negedge clk);
        chk("idle_drop_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_sum", 32'(sum), 32'h17F);
        chk("idle_hold_ovf", 32'(ovf), 32'd1);
        chk("idle_hold_zero", 32'(zero), 32'd0);

        // Input changes between edges must not reach the outputs.
        a = 8'd1; b = 8'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd100; b = 8'd100;
        #2;
        chk("midcycle_sum", 32'(sum), 32'd3);

        // Asynchronous reset while a result is being presented.
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        chk("async_rst_zero", 32'(zero), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // Back-to-back random stream, each result checked one cycle after it is driven.
        esum = '0; eovf = 1'b0; ezero = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_sum", i - 1), 32'(sum), 32'(esum));
                chk($sformatf("stream%0d_ovf", i - 1), 32'(ovf), 32'(eovf));
                chk($sformatf("stream%0d_zero", i - 1), 32'(zero), 32'(ezero));
            end
            if (i < 256) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                model(a, b, cin, sub, esum, eovf, ezero);
                @(negedge clk);
            end
        end
        hold_sum = esum; hold_ovf = eovf; hold_zero = ezero;
        in_valid = 1'b0; a = 'x; b = 'x; cin = 'x; sub = 'x;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_stream%0d_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("post_stream%0d_sum", k), 32'(sum), 32'(hold_sum));
            chk($sformatf("post_stream%0d_ovf", k), 32'(ovf), 32'(hold_ovf));
            chk($sformatf("post_stream%0d_zero", k), 32'(zero), 32'(hold_zero));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
